lsu_initiator: RTL and testbench

- Load/store initiator between the pipeline MEM stage and the data-memory/IO responder (`dm_io`).
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned word accesses.
- Sub-word stores use read-modify-write. Word-crossing misaligned accesses are split into two word accesses.
- Stalls the pipeline via `req_ready` until the access completes.

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_initiator_if.sv | 34 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu_initiator.sv | 219 +++++++++++++++++++++
 tb/tb_lsu_initiator.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store initiator.
//   lsu_state_t  - initiator FSM states
//   F3_*         - RISC-V load/store funct3 encodings
//   DM_CTRL_WORD - access-width code driven on mem_DMCtrl (always word)
//   RGN_DM       - region code of data memory; any other code is IO
//   f3_size / f3_legal / size_mask - funct3 decode helpers
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_CAP,
        S_WR0,
        S_WR1,
        S_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] DM_CTRL_WORD = 3'b010;
    localparam logic [1:0] RGN_DM       = 2'b00;

    // Access size in bytes (1/2/4); illegal codes decode as a word.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    // Stores accept only B/H/W; loads additionally accept BU/HU.
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Right-aligned byte-lane mask for an access of the given size.
    function automatic logic [31:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_initiator_if.sv
// lsu_initiator_if: pipeline request/response channel plus the word-wide
// data-memory/IO bus, bundled for the load/store initiator.
//   slave  modport - the initiator's view (takes requests, drives mem_*)
//   master modport - environment view (pipeline + dm_io responder)
interface lsu_initiator_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_write;
    logic [2:0]        mem_DMCtrl;
    logic              mem_DMwre;
    logic [31:0]       mem_data_read;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_read,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_data_write, mem_DMCtrl, mem_DMwre
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_read,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_data_write, mem_DMCtrl, mem_DMwre
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering over a two-word window.
//   buf_lo/buf_hi - low/high words of the window {buf_hi, buf_lo}
//   off, size     - byte offset into buf_lo and access size in bytes
//   funct3        - selects sign/zero extension for loads
//   wdata         - right-aligned store data
//   rdata         - extracted, extended load result
//   merged_lo/hi  - window with the store bytes inserted at off
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] buf_lo,
    input  logic [31:0] buf_hi,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic [31:0] merged_lo,
    output logic [31:0] merged_hi
);
    logic [63:0] win;
    logic [63:0] lane_mask;
    logic [63:0] lane_data;
    logic [31:0] ext;
    logic [4:0]  sh;

    // Extract and merge share the same little-endian shift amount.
    always_comb begin
        sh        = {off, 3'b000};
        win       = {buf_hi, buf_lo};
        ext       = 32'(win >> sh);
        case (funct3)
            F3_B:    rdata = {{24{ext[7]}}, ext[7:0]};
            F3_BU:   rdata = {24'h0, ext[7:0]};
            F3_H:    rdata = {{16{ext[15]}}, ext[15:0]};
            F3_HU:   rdata = {16'h0, ext[15:0]};
            default: rdata = ext;
        endcase
        lane_mask = {32'h0, size_mask(size)} << sh;
        lane_data = {32'h0, wdata & size_mask(size)} << sh;
        {merged_hi, merged_lo} = (win & ~lane_mask) | (lane_data & lane_mask);
    end
endmodule

// File: rtl/lsu_initiator.sv
// lsu_initiator: turns RISC-V byte/half/word loads and stores into
// word-aligned word accesses on the dm_io bus. Sub-word stores are done as
// read-modify-write; accesses crossing a word boundary are split in two.
// Accesses to the IO region are single-word, never split nor merged.
//   clk, rst - clock, synchronous active-high reset
//   bus      - request/response and memory bus (slave modport)
// Build option: define LSU_MISALIGN_TRAP_EN to reject word-crossing
// accesses with resp_err instead of splitting them.
module lsu_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned IO_SEL_LSB = 10
) (
    input  logic           clk,
    input  logic           rst,
    lsu_initiator_if.slave bus
);
    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] w0_q, w0_d, w1_q, w1_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        size_q, size_d, f3_q, f3_d;
    logic              store_q, store_d, cross_q, cross_d;
    logic [31:0]       wdata_q, wdata_d, buf0_q, buf0_d, hi_q, hi_d;
    logic              ready_q, ready_d, rvalid_q, rvalid_d, rerr_q, rerr_d;
    logic [31:0]       rdata_q, rdata_d, mwdata_q, mwdata_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic              mwre_q, mwre_d;

    logic [ADDR_W-1:0] acc_w0, acc_w1;
    logic [1:0]        acc_off;
    logic [2:0]        acc_size;
    logic              acc_io, acc_cross, acc_legal;
    logic [31:0]       cap_lo, cap_hi, ext_rdata, mrg_lo, mrg_hi;

    // Request decode; IO accesses are word-mapped, so their offset is ignored.
    always_comb begin
        acc_w0    = {bus.req_addr[ADDR_W-1:2], 2'b00};
        acc_w1    = acc_w0 + ADDR_W'(4);
        acc_io    = bus.req_addr[IO_SEL_LSB+1:IO_SEL_LSB] != RGN_DM;
        acc_off   = acc_io ? 2'b00 : bus.req_addr[1:0];
        acc_size  = f3_size(bus.req_funct3);
        acc_cross = (3'(acc_off) + acc_size) > 3'd4;
        acc_legal = f3_legal(bus.req_store, bus.req_funct3);
    end

    // In CAP the second word of a split access arrives straight off the bus.
    assign cap_lo = cross_q ? buf0_q : bus.mem_data_read;
    assign cap_hi = cross_q ? bus.mem_data_read : 32'h0;

    lsu_align u_align (
        .buf_lo    (cap_lo),
        .buf_hi    (cap_hi),
        .wdata     (wdata_q),
        .off       (off_q),
        .size      (size_q),
        .funct3    (f3_q),
        .rdata     (ext_rdata),
        .merged_lo (mrg_lo),
        .merged_hi (mrg_hi)
    );

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d  = state_q;
        w0_d     = w0_q;
        w1_d     = w1_q;
        off_d    = off_q;
        size_d   = size_q;
        f3_d     = f3_q;
        store_d  = store_q;
        cross_d  = cross_q;
        wdata_d  = wdata_q;
        buf0_d   = buf0_q;
        hi_d     = hi_q;
        rdata_d  = rdata_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        mwre_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w0_d    = acc_w0;
                    w1_d    = acc_w1;
                    off_d   = acc_off;
                    size_d  = acc_size;
                    f3_d    = bus.req_funct3;
                    store_d = bus.req_store;
                    cross_d = acc_cross;
                    wdata_d = bus.req_wdata;
                    if (!acc_legal) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (acc_cross) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end
`endif
                    else if (bus.req_store &&
                             (acc_io || (acc_size == 3'd4 && acc_off == 2'd0))) begin
                        // Whole-word write: nothing to preserve, skip the read.
                        state_d  = S_WR0;
                        maddr_d  = acc_w0;
                        mwdata_d = bus.req_wdata & size_mask(acc_size);
                        mwre_d   = 1'b1;
                    end else begin
                        state_d = S_RD0;
                        maddr_d = acc_w0;
                    end
                end
            end
            S_RD0: begin
                if (cross_q) begin
                    state_d = S_RD1;
                    maddr_d = w1_q;
                end else begin
                    state_d = S_CAP;
                end
            end
            S_RD1: begin
                buf0_d  = bus.mem_data_read;
                state_d = S_CAP;
            end
            S_CAP: begin
                buf0_d = cap_lo;
                if (store_q) begin
                    state_d  = S_WR0;
                    maddr_d  = w0_q;
                    mwdata_d = mrg_lo;
                    mwre_d   = 1'b1;
                    hi_d     = mrg_hi;
                end else begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = ext_rdata;
                end
            end
            S_WR0: begin
                if (cross_q) begin
                    state_d  = S_WR1;
                    maddr_d  = w1_q;
                    mwdata_d = hi_q;
                    mwre_d   = 1'b1;
                end else begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                end
            end
            S_WR1: begin
                state_d  = S_RESP;
                rvalid_d = 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            w0_q     <= '0;
            w1_q     <= '0;
            off_q    <= 2'b00;
            size_q   <= 3'd0;
            f3_q     <= 3'd0;
            store_q  <= 1'b0;
            cross_q  <= 1'b0;
            wdata_q  <= 32'h0;
            buf0_q   <= 32'h0;
            hi_q     <= 32'h0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= 32'h0;
            maddr_q  <= '0;
            mwdata_q <= 32'h0;
            mwre_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            off_q    <= off_d;
            size_q   <= size_d;
            f3_q     <= f3_d;
            store_q  <= store_d;
            cross_q  <= cross_d;
            wdata_q  <= wdata_d;
            buf0_q   <= buf0_d;
            hi_q     <= hi_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mwre_q   <= mwre_d;
        end
    end

    assign bus.req_ready      = ready_q;
    assign bus.resp_valid     = rvalid_q;
    assign bus.resp_err       = rerr_q;
    assign bus.resp_rdata     = rdata_q;
    assign bus.mem_address    = maddr_q;
    assign bus.mem_data_write = mwdata_q;
    assign bus.mem_DMwre      = mwre_q;
    assign bus.mem_DMCtrl     = DM_CTRL_WORD;

endmodule

// File: tb/tb_lsu_initiator.sv
// tb_lsu_initiator: directed bench for lsu_initiator with a synchronous
// word memory model (read data one cycle after the address).
module tb_lsu_initiator;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_initiator_if #(.ADDR_W(32)) bus ();

    lsu_initiator #(.ADDR_W(32), .IO_SEL_LSB(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Data memory: 256 words; IO-region writes are not stored.
    logic [31:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        bus.mem_data_read <= mem[bus.mem_address[9:2]];
        if (pre_we)
            mem[pre_idx] <= pre_val;
        else if (bus.mem_DMwre && bus.mem_address[11:10] == 2'b00)
            mem[bus.mem_address[9:2]] <= bus.mem_data_write;
    end

    int          ntest = 0;
    int          nfail = 0;
    int          lat, wr_n, rdy_bad, cnt, nacc, nresp, viol;
    int          wr_k [4];
    logic [31:0] wr_a [4];
    logic [31:0] wr_d [4];
    logic [31:0] ad_log [8];
    logic [31:0] rd, exp_rd, last_rd;
    logic        er, prev_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preset(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // One request; k counts cycles after the accept edge (k=1 is T+1).
    task automatic do_req(input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        chk("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        lat = -1; wr_n = 0; rdy_bad = 0; rd = 32'h0; er = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (k < 8) ad_log[k] = bus.mem_address;
            if (bus.mem_DMwre && wr_n < 4) begin
                wr_k[wr_n] = k; wr_a[wr_n] = bus.mem_address;
                wr_d[wr_n] = bus.mem_data_write; wr_n++;
            end
            if (bus.req_ready) rdy_bad++;
            if (bus.resp_valid) begin
                lat = k; rd = bus.resp_rdata; er = bus.resp_err;
                break;
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        pre_we = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;
        exp_rd = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_dmwre", 32'(bus.mem_DMwre), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_addr", bus.mem_address, 32'h0);
        chk("rst_wdata", bus.mem_data_write, 32'h0);
        chk("rst_dmctrl", 32'(bus.mem_DMCtrl), 32'd2);
        preset(8'd0, 32'h8899_AABB);
        rst = 1'b0;

        // LB / LBU at offset 1
        do_req(1'b0, F3_B, 32'h001, 32'h0);
        chk("lb_rdata", rd, 32'hFFFF_FFAA);
        chk("lb_err", 32'(er), 32'd0);
        chk("lb_lat", 32'(lat), 32'd3);
        chk("lb_writes", 32'(wr_n), 32'd0);
        chk("lb_ready_low", 32'(rdy_bad), 32'd0);
        do_req(1'b0, F3_BU, 32'h001, 32'h0);
        chk("lbu_rdata", rd, 32'h0000_00AA);
        chk("lbu_lat", 32'(lat), 32'd3);
        exp_rd = 32'h0000_00AA;

        // Word-crossing LW at 0x003
        preset(8'd0, 32'h4433_2211);
        preset(8'd1, 32'h8877_6655);
        do_req(1'b0, F3_W, 32'h003, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lwx_lat", 32'(lat), 32'd1);
        chk("lwx_err", 32'(er), 32'd1);
        chk("lwx_rdata_held", rd, exp_rd);
`else
        chk("lwx_lat", 32'(lat), 32'd4);
        chk("lwx_err", 32'(er), 32'd0);
        chk("lwx_rdata", rd, 32'h7766_5544);
        chk("lwx_addr0", ad_log[1], 32'h000);
        chk("lwx_addr1", ad_log[2], 32'h004);
        exp_rd = 32'h7766_5544;
`endif
        chk("lwx_writes", 32'(wr_n), 32'd0);

        // Word-crossing SH 0xBEEF at 0x003
        do_req(1'b1, F3_H, 32'h003, 32'h0000_BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("shx_lat", 32'(lat), 32'd1);
        chk("shx_err", 32'(er), 32'd1);
        chk("shx_writes", 32'(wr_n), 32'd0);
        chk("shx_mem1", mem[1], 32'h8877_6655);
`else
        chk("shx_lat", 32'(lat), 32'd6);
        chk("shx_err", 32'(er), 32'd0);
        chk("shx_writes", 32'(wr_n), 32'd2);
        chk("shx_wr0_cyc", 32'(wr_k[0]), 32'd4);
        chk("shx_wr0_addr", wr_a[0], 32'h000);
        chk("shx_wr0_data", wr_d[0], 32'hEF33_2211);
        chk("shx_wr1_cyc", 32'(wr_k[1]), 32'd5);
        chk("shx_wr1_addr", wr_a[1], 32'h004);
        chk("shx_wr1_data", wr_d[1], 32'h8877_66BE);
        chk("shx_mem1", mem[1], 32'h8877_66BE);
`endif

        // Aligned SW fast path
        do_req(1'b1, F3_W, 32'h008, 32'hCAFE_F00D);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_writes", 32'(wr_n), 32'd1);
        chk("sw_wr_cyc", 32'(wr_k[0]), 32'd1);
        chk("sw_wr_addr", wr_a[0], 32'h008);
        chk("sw_wr_data", wr_d[0], 32'hCAFE_F00D);
        chk("sw_mem2", mem[2], 32'hCAFE_F00D);

        // IO SB: one zero-extended write, no read
        do_req(1'b1, F3_B, 32'h400, 32'hFFFF_FF5A);
        chk("iosb_lat", 32'(lat), 32'd2);
        chk("iosb_writes", 32'(wr_n), 32'd1);
        chk("iosb_wr_addr", wr_a[0], 32'h400);
        chk("iosb_wr_data", wr_d[0], 32'h0000_005A);

        // Illegal funct3: immediate error, bus untouched, rdata held
        do_req(1'b0, 3'b011, 32'h010, 32'h0);
        chk("ill_ld_lat", 32'(lat), 32'd1);
        chk("ill_ld_err", 32'(er), 32'd1);
        chk("ill_ld_rdata", rd, exp_rd);
        chk("ill_ld_writes", 32'(wr_n), 32'd0);
        chk("ill_ld_addr", ad_log[1], 32'h400);
        do_req(1'b1, F3_BU, 32'h010, 32'h0);
        chk("ill_st_lat", 32'(lat), 32'd1);
        chk("ill_st_err", 32'(er), 32'd1);
        chk("ill_st_writes", 32'(wr_n), 32'd0);

        // Non-crossing SB (read-modify-write)
        do_req(1'b1, F3_B, 32'h005, 32'h0000_0077);
        chk("sb_lat", 32'(lat), 32'd4);
        chk("sb_wr_cyc", 32'(wr_k[0]), 32'd3);
        chk("sb_wr_addr", wr_a[0], 32'h004);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("sb_wr_data", wr_d[0], 32'h8877_7755);
`else
        chk("sb_wr_data", wr_d[0], 32'h8877_77BE);
`endif

        // Halfword loads from the top half of word 1
        do_req(1'b0, F3_H, 32'h006, 32'h0);
        chk("lh_rdata", rd, 32'hFFFF_8877);
        chk("lh_lat", 32'(lat), 32'd3);
        do_req(1'b0, F3_HU, 32'h006, 32'h0);
        chk("lhu_rdata", rd, 32'h0000_8877);

`ifndef LSU_MISALIGN_TRAP_EN
        // Reset during WR0 of a crossing SH
        @(negedge clk);
        chk("rstmid_ready_pre", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = F3_H;
        bus.req_addr = 32'h003; bus.req_wdata = 32'h0000_1234;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
        end
        chk("rstmid_wr0_we", 32'(bus.mem_DMwre), 32'd1);
        chk("rstmid_wr0_addr", bus.mem_address, 32'h000);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_we_off", 32'(bus.mem_DMwre), 32'd0);
        chk("rstmid_ready", 32'(bus.req_ready), 32'd1);
        chk("rstmid_no_resp", 32'(bus.resp_valid), 32'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_DMwre || bus.resp_valid) cnt++;
        end
        chk("rstmid_quiet", 32'(cnt), 32'd0);
        chk("rstmid_mem0", mem[0], 32'h3433_2211);
        chk("rstmid_mem1", mem[1], 32'h8877_77BE);
`endif

        // Back-to-back: SW then LW at 0x00C with req_valid held high
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = F3_W;
        bus.req_addr = 32'h00C; bus.req_wdata = 32'h1111_1111;
        nacc = 0; nresp = 0; viol = 0; last_rd = 32'h0;
        prev_rdy = bus.req_ready;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (prev_rdy && bus.req_valid) begin
                nacc++;
                if (nacc == 1) bus.req_store = 1'b0;
                else bus.req_valid = 1'b0;
            end
            if (nacc > nresp && bus.req_ready) viol++;
            if (bus.resp_valid) begin
                nresp++;
                last_rd = bus.resp_rdata;
            end
            prev_rdy = bus.req_ready;
        end
        bus.req_valid = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd2);
        chk("b2b_resps", 32'(nresp), 32'd2);
        chk("b2b_ready_violations", 32'(viol), 32'd0);
        chk("b2b_lw_rdata", last_rd, 32'h1111_1111);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
